spi_sram_seq: RTL and testbench
===============================

# spi_sram_seq

SPI-slave transaction sequencer sitting between the SPI pins and the SRAM array. It deserialises an opcode byte, an address byte and data bytes, sequenced by a loadable 4-bit bit counter. It issues single-cycle SRAM write/read strobes and serialises read data back on `miso`. Burst transfers auto-increment the address.

## Interface
Parameters:
- `ADDR_BITS`, 8: SRAM address width; equals the serial address field length.
- `DATA_BITS`, 8: SRAM word width; equals the serial data field length.

Ports:
- `sck` in 1: the only clock; all logic on posedge.
- `rstN` in 1: reset; asynchronous, active-low.
- `csN` in 1: chip select, active-low, sampled on posedge `sck`.
- `mosi` in 1: serial in, MSB first.
- `miso` out 1: serial out, MSB first.
- `sramAddr` out ADDR_BITS: SRAM address.
- `sramWdata` out DATA_BITS: SRAM write data.
- `sramWe` out 1: one-cycle write strobe.
- `sramRe` out 1: one-cycle read strobe.
- `sramRdata` in DATA_BITS: read data, valid on the first posedge after `sramRe`.
- `busy` out 1: a frame is in progress.
- `cmdErr` out 1: one-cycle pulse on an unknown opcode.

## Operation
- States: CMD (idle/opcode), ADDR, DUMMY, DATA, DROP.
- Bit counter: 4-bit down-counter `cnt`, loaded with 8 on every state entry.
  - Each posedge with `csN`=0 shifts `mosi` into `rxSh` and decrements `cnt`.
  - The edge where `cnt`==1 completes a byte, `byte = {rxSh[6:0], mosi}`.
- `csN`=1 at a posedge:
  - Forces CMD, `cnt`=8 and `miso`=0.
  - No bit is consumed and no strobe is issued.
  - Partial bytes are discarded.
- CMD byte complete:
  - 0x02 sets op=WR and moves to ADDR.
  - 0x03 sets op=RD and moves to ADDR.
  - Any other value moves to DROP and pulses `cmdErr`.
- ADDR byte complete:
  - `addrReg` = byte.
  - WR moves to DATA.
  - RD drives `sramAddr` = byte, pulses `sramRe`, and moves to DUMMY.
- DUMMY: 8 ignored bits. On the last one, `txSh` = `sramRdata`, then move to DATA.
- DATA, WR:
  - On byte completion, `sramAddr` = `addrReg`, `sramWdata` = byte, and `sramWe` pulses.
  - `addrReg` increments, wrapping 0xFF to 0x00.
  - Remain in DATA.
- DATA, RD:
  - `miso` = `txSh[7]`; `txSh` shifts left on each bit.
  - On the first bit of each byte, pulse `sramRe` at `addrReg`+1 (prefetch) and advance `addrReg`.
  - On the last bit, reload `txSh` from `sramRdata`.
- DROP: ignores all bits until `csN`=1.
- `busy` = (state != CMD) or (`cnt` != 8).
- Reset values:
  - State CMD, `cnt`=8, `addrReg`=0, `rxSh`=0, `txSh`=0.
  - `miso`, `sramWe`, `sramRe`, `cmdErr`, `busy` are 0.
  - `sramAddr` and `sramWdata` are 0.

## Timing
- Write strobe:
  - `sramWe` is high for exactly one cycle, starting at the posedge that samples the 8th data bit.
  - `sramAddr` and `sramWdata` are stable during that cycle.
- Read latency:
  - `sramRe` rises at the posedge that samples the last address bit.
  - Data is captured 8 edges later, at the end of DUMMY.
  - The first `miso` bit is valid after that edge.
- Strobe exclusivity:
  - `sramWe` and `sramRe` are never high together.
  - Each strobe lasts one cycle and is deasserted in the following cycle.
- `cmdErr`: one cycle, aligned with the opcode's 8th bit edge.
- `csN` rising on the same edge as a byte's last bit: `csN` wins and no strobe fires.
- Reset assertion mid-frame: all outputs return to their reset values immediately, without waiting for `sck`.

## Structure
- Package `spi_sram_pkg` holds:
  - Opcode constants `OP_WRITE`=8'h02 and `OP_READ`=8'h03.
  - State enum.
  - `CNT_W`=4 and `BYTE_BITS`=8.
- Sub-module `bit_cnt_ld`:
  - 4-bit loadable down-counter with load-8, decrement-enable and `last` (cnt==1) output.
  - Async active-low reset.
- The top level holds the FSM, shift registers, address register and strobe registers.

## Test plan
- Write 0x02, 0x3C, 0xA5 -> exactly one `sramWe` cycle with `sramAddr`=0x3C and `sramWdata`=0xA5; `busy` drops after `csN`=1.
- Burst write 0x02, 0xFF, 0x11, 0x22 -> writes 0x11@0xFF, then 0x22@0x00 (wrap).
- Read 0x03, 0x10, dummy, with SRAM[0x10]=0x5A and SRAM[0x11]=0xC3 -> `miso` shifts 0x5A then 0xC3; `sramRe` at 0x10 then 0x11.
- Opcode 0x9F followed by 16 bits -> one `cmdErr` pulse; no `sramWe`/`sramRe`; `miso`=0.
- `csN` raised after 5 bits of a write data byte -> no `sramWe`; the next frame decodes normally.
- `rstN` pulsed low mid-ADDR with `sck` stopped -> outputs go to 0 immediately; state CMD, `cnt`=8.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Shared constants and types for the SPI-to-SRAM transaction sequencer.
package spi_sram_pkg;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned BYTE_BITS = 8;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DROP
  } state_e;

  typedef enum logic {
    OP_WR,
    OP_RD
  } op_e;

endpackage

// File: rtl/spi_sram_seq_bit_cnt_ld.sv
// Loadable bit down-counter: load forces a full byte count, last flags the final bit.
module bit_cnt_ld
  import spi_sram_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_W'(BYTE_BITS);
    end else if (load) begin
      cnt <= CNT_W'(BYTE_BITS);
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/spi_sram_seq.sv
// SPI-slave sequencer: decodes opcode/address/data bytes and drives single-cycle
// SRAM strobes; reads are prefetched one word ahead and shifted out on miso.
module spi_sram_seq
  import spi_sram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 sck,
  input  logic                 rstN,
  input  logic                 csN,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_BITS-1:0] sramAddr,
  output logic [DATA_BITS-1:0] sramWdata,
  output logic                 sramWe,
  output logic                 sramRe,
  input  logic [DATA_BITS-1:0] sramRdata,
  output logic                 busy,
  output logic                 cmdErr
);

  state_e               state, state_nxt;
  op_e                  op, op_nxt;
  logic [7:0]           rx_sh, rx_sh_nxt, rx_byte;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt, wdata_nxt;
  logic [ADDR_BITS-1:0] addr_reg, addr_nxt, sram_addr_nxt;
  logic                 miso_nxt, we_nxt, re_nxt, err_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 last, first_bit, cnt_load, cnt_dec;

  assign rx_byte   = {rx_sh[6:0], mosi};
  assign first_bit = (cnt == CNT_W'(BYTE_BITS));
  // Reload on every state change and after each completed byte so bursts keep framing.
  assign cnt_load  = csN || (state_nxt != state) || last;
  assign cnt_dec   = !csN;
  assign busy      = (state != ST_CMD) || (cnt != CNT_W'(BYTE_BITS));

  bit_cnt_ld u_bit_cnt (
    .clk  (sck),
    .rst_n(rstN),
    .load (cnt_load),
    .dec  (cnt_dec),
    .cnt  (cnt),
    .last (last)
  );

  always_ff @(posedge sck or negedge rstN) begin
    if (!rstN) begin
      state     <= ST_CMD;
      op        <= OP_WR;
      rx_sh     <= '0;
      tx_sh     <= '0;
      addr_reg  <= '0;
      miso      <= 1'b0;
      sramAddr  <= '0;
      sramWdata <= '0;
      sramWe    <= 1'b0;
      sramRe    <= 1'b0;
      cmdErr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      op        <= op_nxt;
      rx_sh     <= rx_sh_nxt;
      tx_sh     <= tx_sh_nxt;
      addr_reg  <= addr_nxt;
      miso      <= miso_nxt;
      sramAddr  <= sram_addr_nxt;
      sramWdata <= wdata_nxt;
      sramWe    <= we_nxt;
      sramRe    <= re_nxt;
      cmdErr    <= err_nxt;
    end
  end

  // Next-state and next-register decode; chip-select release overrides everything.
  always_comb begin
    state_nxt     = state;
    op_nxt        = op;
    rx_sh_nxt     = rx_sh;
    tx_sh_nxt     = tx_sh;
    addr_nxt      = addr_reg;
    miso_nxt      = miso;
    sram_addr_nxt = sramAddr;
    wdata_nxt     = sramWdata;
    we_nxt        = 1'b0;
    re_nxt        = 1'b0;
    err_nxt       = 1'b0;

    if (csN) begin
      state_nxt = ST_CMD;
      miso_nxt  = 1'b0;
    end else begin
      rx_sh_nxt = rx_byte;
      unique case (state)
        ST_CMD: begin
          if (last) begin
            if (rx_byte == OP_WRITE) begin
              op_nxt    = OP_WR;
              state_nxt = ST_ADDR;
            end else if (rx_byte == OP_READ) begin
              op_nxt    = OP_RD;
              state_nxt = ST_ADDR;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ST_DROP;
            end
          end
        end
        ST_ADDR: begin
          if (last) begin
            addr_nxt = ADDR_BITS'(rx_byte);
            if (op == OP_RD) begin
              sram_addr_nxt = ADDR_BITS'(rx_byte);
              re_nxt        = 1'b1;
              state_nxt     = ST_DUMMY;
            end else begin
              state_nxt = ST_DATA;
            end
          end
        end
        ST_DUMMY: begin
          if (last) begin
            tx_sh_nxt = sramRdata;
            miso_nxt  = sramRdata[DATA_BITS-1];
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (op == OP_WR) begin
            if (last) begin
              sram_addr_nxt = addr_reg;
              wdata_nxt     = DATA_BITS'(rx_byte);
              we_nxt        = 1'b1;
              addr_nxt      = addr_reg + ADDR_BITS'(1);
            end
          end else if (last) begin
            tx_sh_nxt = sramRdata;
            miso_nxt  = sramRdata[DATA_BITS-1];
          end else begin
            tx_sh_nxt = {tx_sh[DATA_BITS-2:0], 1'b0};
            miso_nxt  = tx_sh[DATA_BITS-2];
            // Prefetch the next word so it is ready for the reload at the byte's last bit.
            if (first_bit) begin
              addr_nxt      = addr_reg + ADDR_BITS'(1);
              sram_addr_nxt = addr_reg + ADDR_BITS'(1);
              re_nxt        = 1'b1;
            end
          end
        end
        ST_DROP: begin
          state_nxt = ST_DROP;
        end
        default: state_nxt = ST_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_seq.sv
// Directed bench for spi_sram_seq: drives SPI frames on negedge, models a one-cycle SRAM.
module tb_spi_sram_seq;

  logic       sck = 1'b0;
  logic       sck_en = 1'b1;
  logic       rstN = 1'b0;
  logic       csN = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] sramAddr, sramWdata;
  logic [7:0] sramRdata = 8'h00;
  logic       sramWe, sramRe, busy, cmdErr;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [256];
  logic [7:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  logic [7:0] re_addr_q[$];
  int         err_cnt = 0;
  int         clash_cnt = 0;

  spi_sram_seq #(.ADDR_BITS(8), .DATA_BITS(8)) u_dut (
    .sck      (sck),
    .rstN     (rstN),
    .csN      (csN),
    .mosi     (mosi),
    .miso     (miso),
    .sramAddr (sramAddr),
    .sramWdata(sramWdata),
    .sramWe   (sramWe),
    .sramRe   (sramRe),
    .sramRdata(sramRdata),
    .busy     (busy),
    .cmdErr   (cmdErr)
  );

  always #5 if (sck_en) sck = ~sck;

  // SRAM model: read data appears on the first posedge after the strobe.
  always @(posedge sck) if (sramRe) sramRdata <= mem[sramAddr];

  // Strobe monitor, sampled shortly after each posedge.
  always @(posedge sck) begin
    #2;
    if (sramWe) begin
      we_addr_q.push_back(sramAddr);
      we_data_q.push_back(sramWdata);
    end
    if (sramRe) re_addr_q.push_back(sramAddr);
    if (sramWe && sramRe) clash_cnt++;
    if (cmdErr) err_cnt++;
  end

  task automatic bit_tx(input logic b, output logic so);
    so   = miso;
    csN  = 1'b0;
    mosi = b;
    @(posedge sck);
    @(negedge sck);
  endtask

  task automatic byte_tx(input logic [7:0] v, output logic [7:0] so);
    for (int i = 7; i >= 0; i--) bit_tx(v[i], so[i]);
  endtask

  task automatic end_frame();
    csN  = 1'b1;
    mosi = 1'b0;
    @(posedge sck);
    @(negedge sck);
  endtask

  task automatic test_reset();
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL rst_miso: got %b want 0", miso); end
    total++; if (sramWe !== 1'b0 || sramRe !== 1'b0) begin bad++; $display("FAIL rst_strobes: got we=%b re=%b want 0 0", sramWe, sramRe); end
    total++; if (cmdErr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_err_busy: got err=%b busy=%b want 0 0", cmdErr, busy); end
    total++; if (sramAddr !== 8'h00 || sramWdata !== 8'h00) begin bad++; $display("FAIL rst_bus: got addr=%h wdata=%h want 00 00", sramAddr, sramWdata); end
  endtask

  task automatic test_write();
    logic [7:0] so;
    int w0, r0;
    w0 = we_addr_q.size(); r0 = re_addr_q.size();
    byte_tx(8'h02, so);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_mid: got %b want 1", busy); end
    byte_tx(8'h3C, so);
    byte_tx(8'hA5, so);
    total++; if (sramWe !== 1'b1) begin bad++; $display("FAIL wr_strobe_edge: got %b want 1", sramWe); end
    total++; if (sramAddr !== 8'h3C || sramWdata !== 8'hA5) begin bad++; $display("FAIL wr_bus: got %h/%h want 3c/a5", sramAddr, sramWdata); end
    end_frame();
    total++; if (sramWe !== 1'b0) begin bad++; $display("FAIL wr_strobe_len: got %b want 0", sramWe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    total++; if (we_addr_q.size() - w0 !== 1 || re_addr_q.size() - r0 !== 0) begin bad++; $display("FAIL wr_count: got we=%0d re=%0d want 1 0", we_addr_q.size() - w0, re_addr_q.size() - r0); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] so;
    int w0;
    w0 = we_addr_q.size();
    byte_tx(8'h02, so); byte_tx(8'hFF, so); byte_tx(8'h11, so); byte_tx(8'h22, so);
    end_frame();
    total++; if (we_addr_q.size() - w0 !== 2) begin bad++; $display("FAIL burst_count: got %0d want 2", we_addr_q.size() - w0); end
    total++; if (we_addr_q[w0] !== 8'hFF || we_data_q[w0] !== 8'h11) begin bad++; $display("FAIL burst_w0: got %h@%h want 11@ff", we_data_q[w0], we_addr_q[w0]); end
    total++; if (we_addr_q[w0+1] !== 8'h00 || we_data_q[w0+1] !== 8'h22) begin bad++; $display("FAIL burst_wrap: got %h@%h want 22@00", we_data_q[w0+1], we_addr_q[w0+1]); end
  endtask

  task automatic test_read();
    logic [7:0] so, d0, d1;
    int w0, r0;
    w0 = we_addr_q.size(); r0 = re_addr_q.size();
    byte_tx(8'h03, so);
    byte_tx(8'h10, so);
    total++; if (sramRe !== 1'b1 || sramAddr !== 8'h10) begin bad++; $display("FAIL rd_first_re: got re=%b addr=%h want 1 10", sramRe, sramAddr); end
    byte_tx(8'h00, so);
    byte_tx(8'h00, d0);
    byte_tx(8'h00, d1);
    total++; if (d0 !== 8'h5A) begin bad++; $display("FAIL rd_byte0: got %h want 5a", d0); end
    total++; if (d1 !== 8'hC3) begin bad++; $display("FAIL rd_byte1: got %h want c3", d1); end
    total++; if (miso !== 1'b1) begin bad++; $display("FAIL rd_prefetch_msb: got %b want 1", miso); end
    end_frame();
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL rd_miso_idle: got %b want 0", miso); end
    total++; if (re_addr_q.size() - r0 !== 3 || we_addr_q.size() - w0 !== 0) begin bad++; $display("FAIL rd_count: got re=%0d we=%0d want 3 0", re_addr_q.size() - r0, we_addr_q.size() - w0); end
    total++; if (re_addr_q[r0] !== 8'h10 || re_addr_q[r0+1] !== 8'h11 || re_addr_q[r0+2] !== 8'h12) begin bad++; $display("FAIL rd_addrs: got %h %h %h want 10 11 12", re_addr_q[r0], re_addr_q[r0+1], re_addr_q[r0+2]); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] so, s1, s2;
    int w0, r0, e0;
    w0 = we_addr_q.size(); r0 = re_addr_q.size(); e0 = err_cnt;
    byte_tx(8'h9F, so);
    total++; if (cmdErr !== 1'b1) begin bad++; $display("FAIL err_align: got %b want 1", cmdErr); end
    byte_tx(8'hFF, s1);
    byte_tx(8'hFF, s2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL err_drop_busy: got %b want 1", busy); end
    total++; if ((s1 | s2) !== 8'h00) begin bad++; $display("FAIL err_miso: got %h want 00", s1 | s2); end
    end_frame();
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL err_count: got %0d want 1", err_cnt - e0); end
    total++; if (we_addr_q.size() - w0 !== 0 || re_addr_q.size() - r0 !== 0) begin bad++; $display("FAIL err_strobes: got we=%0d re=%0d want 0 0", we_addr_q.size() - w0, re_addr_q.size() - r0); end
  endtask

  task automatic test_abort();
    logic [7:0] so;
    logic       sb;
    int w0;
    w0 = we_addr_q.size();
    byte_tx(8'h02, so); byte_tx(8'h40, so);
    for (int i = 0; i < 5; i++) bit_tx(1'b1, sb);
    end_frame();
    total++; if (we_addr_q.size() - w0 !== 0) begin bad++; $display("FAIL abort_no_we: got %0d want 0", we_addr_q.size() - w0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    byte_tx(8'h02, so); byte_tx(8'h41, so); byte_tx(8'h66, so);
    end_frame();
    total++; if (we_addr_q.size() - w0 !== 1 || we_addr_q[w0] !== 8'h41 || we_data_q[w0] !== 8'h66) begin bad++; $display("FAIL abort_next: got n=%0d %h@%h want 1 66@41", we_addr_q.size() - w0, we_data_q[w0], we_addr_q[w0]); end
    // csN rises on the edge that would carry the 8th data bit.
    byte_tx(8'h02, so); byte_tx(8'h50, so);
    for (int i = 0; i < 7; i++) bit_tx(1'b0, sb);
    end_frame();
    total++; if (we_addr_q.size() - w0 !== 1) begin bad++; $display("FAIL cs_wins_last: got %0d want 1", we_addr_q.size() - w0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] so;
    logic       sb;
    int w0;
    byte_tx(8'h03, so);
    for (int i = 0; i < 4; i++) bit_tx(1'b1, sb);
    sck_en = 1'b0;
    #20;
    total++; if (busy !== 1'b1 || sramAddr !== 8'h41) begin bad++; $display("FAIL mid_pre: got busy=%b addr=%h want 1 41", busy, sramAddr); end
    rstN = 1'b0;
    #3;
    total++; if (busy !== 1'b0 || miso !== 1'b0 || cmdErr !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl: got busy=%b miso=%b err=%b want 0 0 0", busy, miso, cmdErr); end
    total++; if (sramAddr !== 8'h00 || sramWdata !== 8'h00 || sramWe !== 1'b0 || sramRe !== 1'b0) begin bad++; $display("FAIL mid_rst_bus: got %h %h %b %b want 00 00 0 0", sramAddr, sramWdata, sramWe, sramRe); end
    #10;
    rstN = 1'b1;
    sck_en = 1'b1;
    @(negedge sck);
    end_frame();
    w0 = we_addr_q.size();
    byte_tx(8'h02, so); byte_tx(8'h77, so); byte_tx(8'h88, so);
    end_frame();
    total++; if (we_addr_q.size() - w0 !== 1 || we_addr_q[w0] !== 8'h77 || we_data_q[w0] !== 8'h88) begin bad++; $display("FAIL mid_recover: got n=%0d %h@%h want 1 88@77", we_addr_q.size() - w0, we_data_q[w0], we_addr_q[w0]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'h5A;
    mem[8'h11] = 8'hC3;
    mem[8'h12] = 8'h96;
    repeat (2) @(negedge sck);
    test_reset();
    rstN = 1'b1;
    repeat (2) @(negedge sck);
    test_write();
    test_burst_wrap();
    test_read();
    test_bad_opcode();
    test_abort();
    test_reset_mid();
    total++; if (clash_cnt !== 0) begin bad++; $display("FAIL strobe_clash: got %0d want 0", clash_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
